// File: rtl/ioctl_pkg.sv
// Shared types for the ioctl byte-to-word download sink: FSM states, the FIFO entry layout and lane helpers.
// Entry fields use the widest supported sizes so that one FIFO entry type serves every instance.
package ioctl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } state_t;

    localparam int MAX_DW = 64;
    localparam int MAX_AW = 32;
    localparam int MAX_NB = MAX_DW / 8;
    localparam int CHAN_W = 3;

    typedef struct packed {
        logic [CHAN_W-1:0] chan;
        logic [MAX_AW-1:0] wa;
        logic [MAX_DW-1:0] data;
        logic [MAX_NB-1:0] be;
    } entry_t;

    // Byte-lane address bits for a given word width (0 for byte-wide memories).
    function automatic int lb_of(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ioctl_word_fifo.sv
// Synchronous word FIFO for assembled download words; accepts a push on a full FIFO when a pop happens in the same cycle.
module ioctl_word_fifo
    import ioctl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t din,
    input  logic   pop,
    output entry_t dout,
    output logic   full,
    output logic   empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0] wr_ptr;
    logic [PW:0] rd_ptr;
    entry_t      mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[PW-1:0]] <= din;
    end

endmodule

// File: rtl/ioctl_word_sink.sv
// Packs data_io download bytes into DW-bit words with byte enables and hands them to per-channel
// memory ports through a word FIFO with a level req / pulse ack handshake.
module ioctl_word_sink
    import ioctl_pkg::*;
#(
    parameter int DW         = 16,
    parameter int AW         = 25,
    parameter int CHANNELS   = 2,
    parameter int FIFO_DEPTH = 8,
    parameter int BIG_ENDIAN = 0
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic                ioctl_download,
    input  logic [7:0]          ioctl_index,
    input  logic                ioctl_wr,
    input  logic [AW-1:0]       ioctl_addr,
    input  logic [7:0]          ioctl_dout,
    output logic [CHANNELS-1:0] mem_req,
    input  logic [CHANNELS-1:0] mem_ack,
    output logic [AW-lb_of(DW)-1:0] mem_addr,
    output logic [DW-1:0]       mem_data,
    output logic [DW/8-1:0]     mem_be,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                dropped
);

    localparam int NB  = DW / 8;
    localparam int LB  = lb_of(DW);
    localparam int LW  = (LB > 0) ? LB : 1;
    localparam int WAW = AW - LB;

    state_t            state;
    logic              dl_q;
    logic              rise;
    logic              fall;
    logic [CHAN_W-1:0] chan;
    logic              discard;
    logic              bad_idx;

    logic [LW-1:0]     lane;
    logic [WAW-1:0]    wa;
    logic [NB-1:0]     lane_bit;
    logic              wr_ok;
    logic              last;

    logic [DW-1:0]     asm_data;
    logic [NB-1:0]     asm_be;
    logic [WAW-1:0]    asm_wa;
    logic              asm_full;
    logic [DW-1:0]     nxt_data;
    logic [NB-1:0]     nxt_be;
    logic [WAW-1:0]    nxt_wa;
    logic              nxt_full;
    logic [DW-1:0]     merged;
    logic [NB-1:0]     merged_be;

    logic              push;
    logic [DW-1:0]     push_data;
    logic [NB-1:0]     push_be;
    logic [WAW-1:0]    push_wa;
    logic              push_p1;
    entry_t            push_entry_p1;

    entry_t            head;
    logic              fifo_full;
    logic              fifo_empty;
    logic              req_active;
    logic              pop;
    logic [CHANNELS-1:0] head_sel;
    logic              unused_bits;

    // Byte lane position inside the word honours the configured endianness.
    function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] d, input logic [LW-1:0] ln,
                                               input logic [7:0] b);
        logic [DW-1:0] r;
        int            pos;
        r   = d;
        pos = (BIG_ENDIAN != 0) ? (NB - 1 - int'(ln)) : int'(ln);
        r[pos*8 +: 8] = b;
        return r;
    endfunction

    assign rise     = ioctl_download && !dl_q;
    assign fall     = !ioctl_download && dl_q;
    assign bad_idx  = int'(ioctl_index[5:0]) >= CHANNELS;
    assign lane     = (LB == 0) ? '0 : LW'(ioctl_addr & AW'(NB - 1));
    assign wa       = WAW'(ioctl_addr >> LB);
    assign lane_bit = NB'(1) << lane;
    assign wr_ok    = (state == RUN) && ioctl_download && ioctl_wr && !discard;
    assign last     = (int'(lane) == NB - 1);
    assign merged    = put_byte(asm_data, lane, ioctl_dout);
    assign merged_be = asm_be | lane_bit;

    // At most one word is pushed per cycle; a completed word displaced by an eviction waits in asm_full.
    always_comb begin
        nxt_data  = asm_data;
        nxt_be    = asm_be;
        nxt_wa    = asm_wa;
        nxt_full  = asm_full;
        push      = 1'b0;
        push_data = asm_data;
        push_be   = asm_be;
        push_wa   = asm_wa;
        if (state == RUN) begin
            if (asm_full || (wr_ok && (asm_be != '0) && (wa != asm_wa))) begin
                push     = 1'b1;
                nxt_data = '0;
                nxt_be   = '0;
                nxt_full = 1'b0;
                if (wr_ok) begin
                    nxt_data = put_byte('0, lane, ioctl_dout);
                    nxt_be   = lane_bit;
                    nxt_wa   = wa;
                    nxt_full = last;
                end
            end else if (wr_ok) begin
                if (last) begin
                    push      = 1'b1;
                    push_data = merged;
                    push_be   = merged_be;
                    push_wa   = wa;
                    nxt_data  = '0;
                    nxt_be    = '0;
                end else begin
                    nxt_data = merged;
                    nxt_be   = merged_be;
                    nxt_wa   = wa;
                end
            end
        end else if ((state == FLUSH) && (asm_be != '0)) begin
            push     = 1'b1;
            nxt_data = '0;
            nxt_be   = '0;
            nxt_full = 1'b0;
        end
    end

    // Stage p1: registered word waiting to enter the FIFO
    always_ff @(posedge clk_sys) begin
        if (rise) begin
            asm_data <= '0;
            asm_wa   <= '0;
        end else begin
            asm_data <= nxt_data;
            asm_wa   <= nxt_wa;
        end
        push_entry_p1.chan <= chan;
        push_entry_p1.wa   <= MAX_AW'(push_wa);
        push_entry_p1.data <= MAX_DW'(push_data);
        push_entry_p1.be   <= MAX_NB'(push_be);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            dl_q       <= 1'b0;
            chan       <= '0;
            discard    <= 1'b0;
            asm_be     <= '0;
            asm_full   <= 1'b0;
            push_p1    <= 1'b0;
            req_active <= 1'b0;
            overflow   <= 1'b0;
            dropped    <= 1'b0;
            done       <= 1'b0;
        end else begin
            dl_q    <= ioctl_download;
            done    <= 1'b0;
            push_p1 <= push && !rise;
            if (push_p1 && fifo_full && !pop) overflow <= 1'b1;
            if (rise) begin
                state    <= RUN;
                chan     <= CHAN_W'(ioctl_index[5:0]);
                discard  <= bad_idx;
                dropped  <= bad_idx;
                overflow <= 1'b0;
                asm_be   <= '0;
                asm_full <= 1'b0;
            end else begin
                asm_be   <= nxt_be;
                asm_full <= nxt_full;
                case (state)
                    RUN:     if (fall) state <= FLUSH;
                    FLUSH:   state <= DRAIN;
                    DRAIN: begin
                        if (fifo_empty && !req_active && !push_p1) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // Request rises the cycle after the head becomes valid and drops with the accepting ack
            if (req_active) begin
                if (pop) req_active <= 1'b0;
            end else if (!fifo_empty) begin
                req_active <= 1'b1;
            end
        end
    end

    ioctl_word_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk  (clk_sys),
        .rst_n(reset_n),
        .push (push_p1),
        .din  (push_entry_p1),
        .pop  (pop),
        .dout (head),
        .full (fifo_full),
        .empty(fifo_empty)
    );

    assign head_sel    = CHANNELS'(1) << head.chan;
    assign pop         = req_active && ((mem_ack & head_sel) != '0);
    assign mem_req     = req_active ? head_sel : '0;
    assign mem_addr    = fifo_empty ? '0 : head.wa[WAW-1:0];
    assign mem_data    = fifo_empty ? '0 : head.data[DW-1:0];
    assign mem_be      = fifo_empty ? '0 : head.be[NB-1:0];
    assign busy        = (state != IDLE);
    assign unused_bits = ^{head, ioctl_index[7:6]};

endmodule

// File: tb/tb_ioctl_word_sink.sv
// Directed bench: three sinks (16-bit, 32-bit, 16-bit with a 2-entry FIFO) share one ioctl stream;
// each has its own ack responder that logs accepted words for comparison against hand-computed values.
module tb_ioctl_word_sink;

    typedef struct packed {
        logic [31:0] addr;
        logic [63:0] data;
        logic [7:0]  be;
        logic [7:0]  req;
    } word_t;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic        ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;

    logic [1:0]  req_a, ack_a = '0, be_a;
    logic [23:0] addr_a;
    logic [15:0] data_a;
    logic        busy_a, done_a, ovf_a, drop_a;

    logic [1:0]  req_b, ack_b = '0;
    logic [3:0]  be_b;
    logic [22:0] addr_b;
    logic [31:0] data_b;
    logic        busy_b, done_b, ovf_b, drop_b;

    logic [1:0]  req_c, ack_c = '0, be_c;
    logic [23:0] addr_c;
    logic [15:0] data_c;
    logic        busy_c, done_c, ovf_c, drop_c;

    logic  en_a = 1'b1, en_b = 1'b1, en_c = 1'b1;
    word_t qa[$], qb[$], qc[$];
    int    dn[3] = '{0, 0, 0};
    int    snap[3];
    int    checks = 0;
    int    errors = 0;

    always #5 clk_sys = ~clk_sys;

    ioctl_word_sink #(.DW(16), .AW(25), .CHANNELS(2), .FIFO_DEPTH(8), .BIG_ENDIAN(0)) dut_a (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .mem_req(req_a), .mem_ack(ack_a),
        .mem_addr(addr_a), .mem_data(data_a), .mem_be(be_a), .busy(busy_a), .done(done_a),
        .overflow(ovf_a), .dropped(drop_a));

    ioctl_word_sink #(.DW(32), .AW(25), .CHANNELS(2), .FIFO_DEPTH(8), .BIG_ENDIAN(0)) dut_b (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .mem_req(req_b), .mem_ack(ack_b),
        .mem_addr(addr_b), .mem_data(data_b), .mem_be(be_b), .busy(busy_b), .done(done_b),
        .overflow(ovf_b), .dropped(drop_b));

    ioctl_word_sink #(.DW(16), .AW(25), .CHANNELS(2), .FIFO_DEPTH(2), .BIG_ENDIAN(0)) dut_c (
        .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
        .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .mem_req(req_c), .mem_ack(ack_c),
        .mem_addr(addr_c), .mem_data(data_c), .mem_be(be_c), .busy(busy_c), .done(done_c),
        .overflow(ovf_c), .dropped(drop_c));

    // Responders: one-cycle ack per request, logging the presented word.
    always @(negedge clk_sys) begin
        if (ack_a != '0) ack_a = '0;
        else if (en_a && req_a != '0) begin
            ack_a = req_a;
            qa.push_back({32'(addr_a), 64'(data_a), 8'(be_a), 8'(req_a)});
        end
        if (done_a) dn[0]++;
    end

    always @(negedge clk_sys) begin
        if (ack_b != '0) ack_b = '0;
        else if (en_b && req_b != '0) begin
            ack_b = req_b;
            qb.push_back({32'(addr_b), 64'(data_b), 8'(be_b), 8'(req_b)});
        end
        if (done_b) dn[1]++;
    end

    always @(negedge clk_sys) begin
        if (ack_c != '0) ack_c = '0;
        else if (en_c && req_c != '0) begin
            ack_c = req_c;
            qc.push_back({32'(addr_c), 64'(data_c), 8'(be_c), 8'(req_c)});
        end
        if (done_c) dn[2]++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_word(input string tag, input word_t q[$], input int i, input logic [31:0] a,
                              input logic [63:0] d, input logic [7:0] be, input logic [7:0] rq);
        word_t w;
        w = '0;
        if (i < q.size()) w = q[i];
        check({tag, ".addr"}, 64'(w.addr), 64'(a));
        check({tag, ".data"}, w.data, d);
        check({tag, ".be"},   64'(w.be), 64'(be));
        check({tag, ".req"},  64'(w.req), 64'(rq));
    endtask

    task automatic start(input logic [7:0] idx);
        qa.delete(); qb.delete(); qc.delete();
        snap = dn;
        @(negedge clk_sys);
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic wbyte(input int a, input logic [7:0] d);
        ioctl_addr = 25'(a);
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk_sys);
        ioctl_wr = 1'b0;
        @(negedge clk_sys);
    endtask

    task automatic stop();
        @(negedge clk_sys);
        ioctl_download = 1'b0;
    endtask

    task automatic wait_done(input int k, input string tag);
        int n;
        n = 0;
        while (dn[k] == snap[k] && n < 400) begin
            @(negedge clk_sys);
            n++;
        end
        check(tag, 64'(dn[k] - snap[k]), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n        = 1'b0;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = '0;
        repeat (3) @(negedge clk_sys);
        check("rst.req",  64'(req_a), 64'd0);
        check("rst.busy", 64'(busy_a), 64'd0);
        check("rst.flags", 64'({done_a, ovf_a, drop_a}), 64'd0);
        check("rst.data", 64'(data_a), 64'd0);
        reset_n = 1'b1;

        // 16-bit packing, two full words
        start(8'd0);
        check("t1.busy", 64'(busy_a), 64'd1);
        wbyte(0, 8'h11); wbyte(1, 8'h22); wbyte(2, 8'h33); wbyte(3, 8'h44);
        stop();
        wait_done(0, "t1.done_a"); wait_done(1, "t1.done_b"); wait_done(2, "t1.done_c");
        check("t1.cnt", 64'(qa.size()), 64'd2);
        check_word("t1.w0", qa, 0, 32'd0, 64'h2211, 8'h3, 8'h1);
        check_word("t1.w1", qa, 1, 32'd1, 64'h4433, 8'h3, 8'h1);
        check_word("t1.b0", qb, 0, 32'd0, 64'h44332211, 8'hF, 8'h1);
        check("t1.idle", 64'(busy_a), 64'd0);

        // 32-bit: full word then partial word on flush
        start(8'd0);
        for (int i = 0; i < 5; i++) wbyte(i, 8'(8'hA0 + i));
        stop();
        wait_done(0, "t2.done_a"); wait_done(1, "t2.done_b"); wait_done(2, "t2.done_c");
        check("t2.cnt", 64'(qb.size()), 64'd2);
        check_word("t2.b0", qb, 0, 32'd0, 64'hA3A2A1A0, 8'hF, 8'h1);
        check_word("t2.b1", qb, 1, 32'd1, 64'h000000A4, 8'h1, 8'h1);
        check_word("t2.a2", qa, 2, 32'd2, 64'h00A4, 8'h1, 8'h1);

        // Address jump evicts a partial word
        start(8'd0);
        wbyte(0, 8'h5A); wbyte(6, 8'hC3);
        stop();
        wait_done(0, "t3.done_a"); wait_done(1, "t3.done_b"); wait_done(2, "t3.done_c");
        check_word("t3.a0", qa, 0, 32'd0, 64'h005A, 8'h1, 8'h1);
        check_word("t3.a1", qa, 1, 32'd3, 64'h00C3, 8'h1, 8'h1);
        check_word("t3.b1", qb, 1, 32'd1, 64'h00C30000, 8'h4, 8'h1);

        // Out-of-range channel index discards the download
        start(8'd3);
        check("t4.drop", 64'(drop_a), 64'd1);
        wbyte(0, 8'h99); wbyte(1, 8'h98);
        stop();
        wait_done(0, "t4.done_a"); wait_done(1, "t4.done_b"); wait_done(2, "t4.done_c");
        check("t4.cnt", 64'(qa.size()), 64'd0);
        check("t4.drop_hold", 64'(drop_a), 64'd1);
        start(8'd1);
        check("t4.drop_clr", 64'(drop_a), 64'd0);
        wbyte(0, 8'h12); wbyte(1, 8'h34);
        stop();
        wait_done(0, "t4b.done_a"); wait_done(1, "t4b.done_b"); wait_done(2, "t4b.done_c");
        check_word("t4.ch1", qa, 0, 32'd0, 64'h3412, 8'h3, 8'h2);

        // Overflow on the 2-entry FIFO with acks withheld
        en_c = 1'b0;
        start(8'd0);
        for (int i = 0; i < 16; i++) wbyte(i, 8'(i + 1));
        stop();
        repeat (20) @(negedge clk_sys);
        check("t5.c_none", 64'(qc.size()), 64'd0);
        check("t5.ovf", 64'(ovf_c), 64'd1);
        check("t5.busy", 64'(busy_c), 64'd1);
        check("t5.a_ovf", 64'(ovf_a), 64'd0);
        en_c = 1'b1;
        wait_done(0, "t5.done_a"); wait_done(1, "t5.done_b"); wait_done(2, "t5.done_c");
        check("t5.c_cnt", 64'(qc.size()), 64'd2);
        check_word("t5.c0", qc, 0, 32'd0, 64'h0201, 8'h3, 8'h1);
        check_word("t5.c1", qc, 1, 32'd1, 64'h0403, 8'h3, 8'h1);
        check("t5.a_cnt", 64'(qa.size()), 64'd8);
        check_word("t5.a7", qa, 7, 32'd7, 64'h100F, 8'h3, 8'h1);

        // Asynchronous reset while a request is pending
        en_a = 1'b0;
        start(8'd0);
        wbyte(0, 8'h55); wbyte(1, 8'h66);
        stop();
        for (int n = 0; n < 50 && req_a[0] !== 1'b1; n++) @(negedge clk_sys);
        check("t6.req_pend", 64'(req_a), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("t6.req_rst", 64'(req_a), 64'd0);
        check("t6.busy_rst", 64'(busy_a), 64'd0);
        check("t6.data_rst", 64'(data_a), 64'd0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        en_a    = 1'b1;
        start(8'd0);
        wbyte(0, 8'h77); wbyte(1, 8'h88);
        stop();
        wait_done(0, "t6.done_a"); wait_done(1, "t6.done_b"); wait_done(2, "t6.done_c");
        check("t6.cnt", 64'(qa.size()), 64'd1);
        check_word("t6.a0", qa, 0, 32'd0, 64'h8877, 8'h3, 8'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
